// File: rtl/ca_gen_ctrl.sv
// ca_gen_ctrl: generation sequencer for a 1-D array of JK-coded CA cells.
//
// The block seeds the cell array. Then, for each generation, it works out every
// cell's next state from an 8-bit Wolfram rule and the cell's 3-cell
// neighbourhood. It drives a 2-bit JK code per cell (00 keep, 01 clear,
// 10 set) and gives a one-cycle cell_tick; the cells act on the rising edge
// of cell_tick.
//
// Each operation walks SETUP -> TICK -> HOLD. cell_sig is registered on
// the entry edge into SETUP and held through HOLD. Outside those three
// cycles cell_sig is 00. In run mode, WAIT pads the loop so that cell_tick
// rises every DIV cycles.
//
// Parameters: WIDTH (cells), DIV (run period, >= 4), GEN_W (counter width).
// Ports:
//   clock, reset      system clock, asynchronous active-low reset
//   load, seed        load seed pattern (IDLE only, highest priority)
//   start, step, stop run continuously / one generation / halt after current
//   rule              Wolfram rule, sampled as each generation enters SETUP
//   gen_limit         stop when gen_count reaches it; 0 = unlimited
//   cell_state        current cell outputs fed back from the array
//   cell_sig          JK code, cell i on bits [2i+1:2i]
//   cell_tick         update pulse to the cells
//   busy, done        not-IDLE flag / one-cycle limit-reached pulse
//   gen_count         generations completed since the last load
// Configuration macro: CA_WRAP_EN selects a toroidal boundary. When it is
// undefined, the boundary is fixed and out-of-range neighbours read as 0.

module ca_gen_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 16,
    parameter int GEN_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   seed,
    input  logic               start,
    input  logic               step,
    input  logic               stop,
    input  logic [7:0]         rule,
    input  logic [GEN_W-1:0]   gen_limit,
    input  logic [WIDTH-1:0]   cell_state,
    output logic [2*WIDTH-1:0] cell_sig,
    output logic               cell_tick,
    output logic               busy,
    output logic               done,
    output logic [GEN_W-1:0]   gen_count
);

    localparam int WCW = (DIV > 4) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, TICK, HOLD, WAIT} state_t;

    state_t             state;
    logic               run_flag;
    logic               is_load;   // current pass is a seed load, not a generation
    logic [WCW-1:0]     wait_cnt;
    logic [WIDTH-1:0]   left, right, nxt;
    logic [2*WIDTH-1:0] gen_sig, load_sig;

    // Neighbourhood, rule lookup and JK encoding for every cell
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i == WIDTH - 1) begin : g_left_edge
`ifdef CA_WRAP_EN
            assign left[i] = cell_state[0];
`else
            assign left[i] = 1'b0;
`endif
        end else begin : g_left
            assign left[i] = cell_state[i+1];
        end
        if (i == 0) begin : g_right_edge
`ifdef CA_WRAP_EN
            assign right[i] = cell_state[WIDTH-1];
`else
            assign right[i] = 1'b0;
`endif
        end else begin : g_right
            assign right[i] = cell_state[i-1];
        end
        assign nxt[i] = rule[{left[i], cell_state[i], right[i]}];
        assign gen_sig[2*i +: 2]  = (nxt[i] == cell_state[i]) ? 2'b00 :
                                    (nxt[i] ? 2'b10 : 2'b01);
        assign load_sig[2*i +: 2] = seed[i] ? 2'b10 : 2'b01;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cell_sig  <= '0;
            cell_tick <= 1'b0;
            done      <= 1'b0;
            gen_count <= '0;
            run_flag  <= 1'b0;
            is_load   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (stop)
                run_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        is_load  <= 1'b1;
                        cell_sig <= load_sig;
                        state    <= SETUP;
                    end else if (start && !stop) begin
                        // A stop in the same cycle as start suppresses the run
                        run_flag <= 1'b1;
                        is_load  <= 1'b0;
                        cell_sig <= gen_sig;
                        state    <= SETUP;
                    end else if (step && !start) begin
                        is_load  <= 1'b0;
                        cell_sig <= gen_sig;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    cell_tick <= 1'b1;
                    if (!is_load)
                        gen_count <= gen_count + 1'b1;
                    state <= TICK;
                end
                TICK: begin
                    cell_tick <= 1'b0;
                    state     <= HOLD;
                end
                HOLD: begin
                    cell_sig <= '0;
                    if (is_load) begin
                        gen_count <= '0;
                        state     <= IDLE;
                    end else if (gen_limit != '0 && gen_count == gen_limit) begin
                        done     <= 1'b1;
                        run_flag <= 1'b0;
                        state    <= IDLE;
                    end else if (run_flag && !stop) begin
                        // SETUP+TICK+HOLD plus DIV-3 WAIT cycles gives a DIV period
                        wait_cnt <= WCW'(DIV - 4);
                        state    <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (wait_cnt == '0) begin
                        cell_sig <= gen_sig;
                        state    <= SETUP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ca_gen_ctrl.sv
// Bench for ca_gen_ctrl. A small JK cell-array model feeds cell_state back.
// Expected tick contents and done pulses are queued when a command is issued.
// A negedge monitor pops and compares them whenever the DUT ticks or signals done.

module tb_ca_gen_ctrl;

    localparam int W   = 8;
    localparam int DIV = 4;
    localparam int GW  = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          load = 1'b0, start = 1'b0, step = 1'b0, stop = 1'b0;
    logic [W-1:0]  seed = '0;
    logic [7:0]    rule = '0;
    logic [GW-1:0] gen_limit = '0;
    logic [W-1:0]  cells = '0;
    logic [2*W-1:0] cell_sig;
    logic          cell_tick, busy, done;
    logic [GW-1:0] gen_count;

    ca_gen_ctrl #(.WIDTH(W), .DIV(DIV), .GEN_W(GW)) dut (
        .clock(clock), .reset(reset), .load(load), .seed(seed), .start(start),
        .step(step), .stop(stop), .rule(rule), .gen_limit(gen_limit),
        .cell_state(cells), .cell_sig(cell_sig), .cell_tick(cell_tick),
        .busy(busy), .done(done), .gen_count(gen_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] sig;
        logic [15:0] gc;
    } exp_t;

    exp_t        tick_q[$];
    logic [15:0] done_q[$];
    time         tick_t[$];
    int          tests = 0, fails = 0, ndone = 0;
    exp_t        e;
    logic [15:0] dexp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cell array model: JK cells acting on the rising edge of cell_tick
    always @(posedge cell_tick) begin
        for (int i = 0; i < W; i++)
            case (cell_sig[2*i +: 2])
                2'b01: cells[i] <= 1'b0;
                2'b10: cells[i] <= 1'b1;
                2'b11: cells[i] <= ~cells[i];
                default: ;
            endcase
    end

    // Monitor
    always @(negedge clock) begin
        if (reset && cell_tick) begin
            tick_t.push_back($time);
            if (tick_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_tick: got tick with sig %h expected none", cell_sig);
            end else begin
                e = tick_q.pop_front();
                check("tick_sig", 32'(cell_sig), 32'(e.sig));
                check("tick_gen", 32'(gen_count), 32'(e.gc));
            end
        end
        if (reset && done) begin
            ndone++;
            if (done_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done: got done expected none");
            end else begin
                dexp = done_q.pop_front();
                check("done_gen", 32'(gen_count), 32'(dexp));
            end
        end
    end

    function automatic exp_t mk(input logic [15:0] s, input logic [15:0] g);
        exp_t r;
        r.sig = s; r.gc = g;
        return r;
    endfunction

    // Single-cycle command pulse; the DUT samples it at edge k and the task
    // returns 1ns after k.
    task automatic pulse(input bit l, input bit st, input bit sp, input bit so);
        @(posedge clock); #1;
        load = l; start = st; step = sp; stop = so;
        @(posedge clock); #1;
        load = 0; start = 0; step = 0; stop = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    int n0;

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_sig", 32'(cell_sig), 32'd0);
        check("rst_tick", 32'(cell_tick), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_gen", 32'(gen_count), 32'd0);
        reset = 1'b1;

        // 1: load 0x10
        seed = 8'h10;
        tick_q.push_back(mk(16'h5655, 16'd0));
        pulse(1, 0, 0, 0);
        wait_idle("load1_idle");
        check("load1_gen", 32'(gen_count), 32'd0);
        check("load1_cells", 32'(cells), 32'h10);

        // 2: rule 90 step, with latency checks
        rule = 8'd90;
        tick_q.push_back(mk(16'h0980, 16'd1));
        pulse(0, 0, 1, 0);
        check("step_sig_k", 32'(cell_sig), 32'h0980);
        check("step_busy_k", 32'(busy), 32'd1);
        check("step_tick_k", 32'(cell_tick), 32'd0);
        @(posedge clock); #1;
        check("step_tick_k1", 32'(cell_tick), 32'd1);
        @(posedge clock); #1;
        check("step_busy_k2", 32'(busy), 32'd1);
        check("step_sig_k2", 32'(cell_sig), 32'h0980);
        @(posedge clock); #1;
        check("step_busy_k3", 32'(busy), 32'd0);
        check("step_sig_k3", 32'(cell_sig), 32'd0);
        check("step_gen", 32'(gen_count), 32'd1);
        check("step_cells", 32'(cells), 32'h28);

        // 3: seed 0x01, rule 90 step; boundary-dependent result
        seed = 8'h01;
        tick_q.push_back(mk(16'h5556, 16'd1));
        pulse(1, 0, 0, 0);
        wait_idle("load2_idle");
        check("load2_gen", 32'(gen_count), 32'd0);
`ifdef CA_WRAP_EN
        tick_q.push_back(mk(16'h8009, 16'd1));
`else
        tick_q.push_back(mk(16'h0009, 16'd1));
`endif
        pulse(0, 0, 1, 0);
        wait_idle("bnd_idle");
`ifdef CA_WRAP_EN
        check("bnd_cells", 32'(cells), 32'h82);
`else
        check("bnd_cells", 32'(cells), 32'h02);
`endif

        // 4: identity rule still ticks and counts
        rule = 8'd204;
        n0 = tick_t.size();
        tick_q.push_back(mk(16'h0000, 16'd2));
        pulse(0, 0, 1, 0);
        wait_idle("id_idle");
        check("id_ticks", 32'(tick_t.size() - n0), 32'd1);
        check("id_gen", 32'(gen_count), 32'd2);

        // 5: gen_limit=3 run
        seed = 8'h10;
        tick_q.push_back(mk(16'h5655, 16'd2));
        pulse(1, 0, 0, 0);
        wait_idle("load3_idle");
        gen_limit = 16'd3;
        rule = 8'd90;
        n0 = tick_t.size();
        tick_q.push_back(mk(16'h0980, 16'd1));
        tick_q.push_back(mk(16'h2460, 16'd2));
        tick_q.push_back(mk(16'h9898, 16'd3));
        done_q.push_back(16'd3);
        pulse(0, 1, 0, 0);
        wait_idle("run_idle");
        @(posedge clock); #1;
        check("run_ticks", 32'(tick_t.size() - n0), 32'd3);
        if (tick_t.size() - n0 == 3) begin
            check("run_gap1", 32'(tick_t[n0+1] - tick_t[n0]), 32'd40);
            check("run_gap2", 32'(tick_t[n0+2] - tick_t[n0+1]), 32'd40);
        end
        check("run_ndone", 32'(ndone), 32'd1);
        check("run_gen", 32'(gen_count), 32'd3);
        check("run_cells", 32'(cells), 32'hAA);
        check("run_done_low", 32'(done), 32'd0);

        // 6a: stop while in WAIT
        gen_limit = '0;
        rule = 8'd204;
        tick_q.push_back(mk(16'h0000, 16'd4));
        pulse(0, 1, 0, 0);
        @(posedge clock); #1;   // TICK
        @(posedge clock); #1;   // HOLD
        @(posedge clock); #1;   // WAIT
        stop = 1'b1;
        @(posedge clock); #1;
        stop = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        repeat (8) @(posedge clock);
        #1;
        check("stop_gen", 32'(gen_count), 32'd4);

        // 6b: start with stop in IDLE does nothing
        pulse(0, 1, 0, 1);
        check("ss_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clock);
        #1;
        check("ss_gen", 32'(gen_count), 32'd4);

        // 6c: reset during TICK
        rule = 8'd90;
`ifdef CA_WRAP_EN
        tick_q.push_back(mk(16'h4444, 16'd5));
`else
        tick_q.push_back(mk(16'h4446, 16'd5));
`endif
        pulse(0, 0, 1, 0);
        @(posedge clock); #1;
        check("rt_tick_hi", 32'(cell_tick), 32'd1);
        #6;
        reset = 1'b0;
        #1;
        check("rt_sig", 32'(cell_sig), 32'd0);
        check("rt_tick", 32'(cell_tick), 32'd0);
        check("rt_busy", 32'(busy), 32'd0);
        check("rt_done", 32'(done), 32'd0);
        check("rt_gen", 32'(gen_count), 32'd0);
        #2;
        reset = 1'b1;
        n0 = tick_t.size();
        repeat (4) @(posedge clock);
        #1;
        check("rt_still_idle", 32'(busy), 32'd0);
        check("rt_no_tick", 32'(tick_t.size() - n0), 32'd0);

        check("tick_q_empty", 32'(tick_q.size()), 32'd0);
        check("done_q_empty", 32'(done_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
